// File: rtl/ymux_pkg.sv
// Shared definitions for the ymux_n_reg registered channel multiplexer.
package ymux_pkg;

    // Channel selection modes
    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    localparam int unsigned DEFAULT_W = 2;
    localparam int unsigned DEFAULT_N = 4;

    typedef enum logic {StEmpty, StFull} state_e;

    // Ceiling log2, never less than 1 so an index port always has a bit
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/ymux_rr_arb.sv
// Round-robin search: first requesting channel at or above ptr, wrapping N-1 -> 0.
module ymux_rr_arb
    import ymux_pkg::*;
#(
    parameter int unsigned N = DEFAULT_N,
    localparam int unsigned SW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] gnt_idx
);

    int unsigned idx;
    logic        found;

    // Scan N positions starting at ptr; the first hit wins
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (enable && !found && req[idx[SW-1:0]]) begin
                found                = 1'b1;
                gnt[idx[SW-1:0]]     = 1'b1;
                gnt_idx              = idx[SW-1:0];
            end
        end
    end

endmodule

// File: rtl/ymux_n_reg.sv
// N-channel to one registered output mux with explicit or round-robin selection.
// Optional build macro: YMUX_PARITY_EN adds out_par, the registered parity of out_data.
module ymux_n_reg
    import ymux_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W,
    parameter int unsigned N = DEFAULT_N,
    localparam int unsigned SW = clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]  in_valid,
    output logic [N-1:0]  in_ready,
    input  logic [SW-1:0] sel,
    input  logic          mode,
    output logic [W-1:0]  out_data,
    output logic [SW-1:0] out_ch,
    output logic          out_valid,
    input  logic          out_ready
`ifdef YMUX_PARITY_EN
    ,
    output logic          out_par
`endif
);

    state_e        state_q, state_d;
    logic [W-1:0]  data_q;
    logic [SW-1:0] ch_q;
    logic [SW-1:0] rr_ptr_q;
    logic          slot_free;
    logic [N-1:0]  rr_gnt;
    logic [SW-1:0] rr_idx;
    logic          xfer;
    logic [SW-1:0] xfer_ch;
    logic [W-1:0]  xfer_data;

    ymux_rr_arb #(
        .N(N)
    ) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .enable  (mode == MODE_RR),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx)
    );

    // Output register occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StEmpty;
        else        state_q <= state_d;
    end

    // A transfer always fills the slot; otherwise a drain empties it
    always_comb begin
        state_d = state_q;
        if (xfer)           state_d = StFull;
        else if (out_ready) state_d = StEmpty;
    end

    // Status outputs; the slot can accept when empty or being drained this cycle
    always_comb begin
        out_valid = (state_q == StFull);
        slot_free = (state_q == StEmpty) || out_ready;
    end

    // Per-channel accept; out-of-range sel grants nothing, and reset masks everything
    always_comb begin
        in_ready = '0;
        if (mode == MODE_RR) begin
            in_ready = rr_gnt & {N{slot_free}};
        end else if (32'(sel) < N) begin
            in_ready[sel] = slot_free;
        end
        if (!rst_n) in_ready = '0;
    end

    // Select the granted channel's data
    always_comb begin
        xfer      = |(in_ready & in_valid);
        xfer_ch   = (mode == MODE_RR) ? rr_idx : sel;
        xfer_data = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (SW'(k) == xfer_ch) xfer_data = in_data[k*W +: W];
        end
    end

    // Output data register and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            ch_q     <= '0;
            rr_ptr_q <= '0;
        end else if (xfer) begin
            data_q <= xfer_data;
            ch_q   <= xfer_ch;
            if (mode == MODE_RR) begin
                rr_ptr_q <= (xfer_ch == SW'(N - 1)) ? '0 : xfer_ch + 1'b1;
            end
        end
    end

    assign out_data = data_q;
    assign out_ch   = ch_q;

`ifdef YMUX_PARITY_EN
    logic par_q;

    // Parity tracks out_data, loaded on the same transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    par_q <= 1'b0;
        else if (xfer) par_q <= ^xfer_data;
    end

    assign out_par = par_q;
`endif

endmodule

// File: doc/ymux_n_reg.md
YMUX_N_REG -- requirements
Module: ymux_n_reg

Interface
REQ-001 SHALL have parameter W, default 2, bit width of each channel.
REQ-002 SHALL have parameter N, default 4, channel count, legal range 2..16.
REQ-003 SHALL have localparam SW = clog2(N), min 1, width of channel index.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_data  input  N*W  flattened channels, channel k at bits [k*W+W-1:k*W].
REQ-007 SHALL have port in_valid  input  N  per-channel request.
REQ-008 SHALL have port in_ready  output  N  per-channel accept; one-hot or zero.
REQ-009 SHALL have port sel  input  SW  explicit channel index, used in mode 0.
REQ-010 SHALL have port mode  input  1  0 = explicit select, 1 = round-robin over valid channels.
REQ-011 SHALL have port out_data  output  W  registered selected data.
REQ-012 SHALL have port out_ch  output  SW  index of the channel held in out_data.
REQ-013 SHALL have port out_valid  output  1  output register holds data.
REQ-014 SHALL have port out_ready  input  1  downstream accept.

Function
REQ-015 SHALL hold one output register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL define slot-free as (state==EMPTY) or out_ready=1, evaluated combinationally in the same cycle.
REQ-017 SHALL, in mode 0, assert in_ready[sel] = slot-free only when sel<N; all other in_ready bits SHALL be 0.
REQ-018 SHALL, in mode 1, grant the first channel with in_valid=1 searching upward from rr_ptr with wrap N-1 -> 0, and assert in_ready for that channel only when slot-free.
REQ-019 SHALL transfer on an input channel k when in_valid[k] and in_ready[k] are both 1; on the next edge out_data = channel k data, out_ch = k, state = FULL. Latency is 1 cycle.
REQ-020 SHALL, when out_ready=1 in FULL and no input transfer occurs, go EMPTY on the next edge.
REQ-021 SHALL, on simultaneous output drain and input transfer, stay FULL with new data, giving full throughput of 1 word per cycle.
REQ-022 SHALL hold out_data and out_ch stable while FULL and out_ready=0.
REQ-023 SHALL set rr_ptr = (k+1) mod N after each mode-1 transfer from channel k; rr_ptr SHALL be unchanged otherwise, including in mode 0.
REQ-024 SHALL treat sel>=N (N not a power of two) as no grant; state SHALL be unaffected.
REQ-025 SHALL take effect on the next cycle's grant when mode changes; a held FULL word SHALL be unaffected.

Reset
REQ-026 SHALL, on rst_n=0 at any time, immediately force out_valid=0, out_data=0, out_ch=0, rr_ptr=0, state EMPTY; an in-flight word is discarded.
REQ-027 SHALL drive in_ready=0 while rst_n=0.
REQ-028 SHALL allow the first transfer on the first rising edge after rst_n returns to 1.

Configuration
REQ-029 SHALL, with macro YMUX_PARITY_EN defined, add output out_par (1 bit), the registered even parity (XOR-reduce) of out_data, updated with it and reset to 0.
REQ-030 SHALL, without YMUX_PARITY_EN, omit the out_par port and its logic entirely.

Structure
REQ-031 SHALL place the mode encodings (MODE_SEL=0, MODE_RR=1), the default W and N, and a clog2 function in package ymux_pkg.
REQ-032 SHALL implement the mode-1 search and pointer in sub-module ymux_rr_arb (inputs: req[N], ptr, enable; outputs: one-hot grant, grant index).

Verification
REQ-033 SHALL cover mode 0 with N=4, W=2: data 11,10,01,00, sel=2, all valid, out_ready=1 -> next cycle out_data=10, out_ch=2, in_ready=0100.
REQ-034 SHALL cover mode 1 with all valid and out_ready=1 held 5 cycles -> out_ch sequence 0,1,2,3,0.
REQ-035 SHALL cover mode 1 with in_valid=1010 and rr_ptr=2 -> grant channel 3, then channel 1, with channels 0 and 2 never granted.
REQ-036 SHALL cover backpressure: FULL with out_ready=0 for 3 cycles -> in_ready=0000, out_data unchanged; at out_ready=1 with a valid input, drain and refill occur in the same edge.
REQ-037 SHALL cover N=3 with sel=3 -> in_ready=000 and out_valid stays 0.
REQ-038 SHALL cover rst_n pulsed low mid-cycle while FULL -> out_valid=0 immediately without a clock edge; the next grant after release starts at channel 0.
